// File: rtl/avr2wb_async_avr_if.sv
// Bridge link between the AVR-side front end and the Wishbone-side stage.
// master = AVR front end (drives requests), slave = Wishbone stage (returns done/data).
interface avr2wb_async_avr_if;
  logic [31:0] wb_adr;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_be;
  logic        wb_read;
  logic        wb_write;
  logic [31:0] wb_rdata;
  logic        wb_done;
  logic        wb_error;

  // Request levels stay high until the resynchronised done edge is seen.
  // wb_rdata/wb_error must be stable while wb_done is high.
  modport master (
    output wb_adr, wb_wdata, wb_be, wb_read, wb_write,
    input  wb_rdata, wb_done, wb_error
  );

  modport slave (
    input  wb_adr, wb_wdata, wb_be, wb_read, wb_write,
    output wb_rdata, wb_done, wb_error
  );
endinterface

// File: rtl/avr2wb_async_avr.sv
// AVR-clock-domain front end of the AVR-to-Wishbone async bridge: 16-byte I/O
// window, level read/write requests, resynchronised done capture.
module avr2wb_async_avr #(
  parameter logic [5:0] P_BASE_ADR    = 6'h30,
  parameter int         P_SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [5:0]               adr,
  input  logic                     iore,
  input  logic                     iowe,
  input  logic [7:0]               dbus_in,
  output logic [7:0]               dbus_out,
  output logic                     out_en,
  output logic                     irq,
  output logic [1:0]               dbg_state,
  avr2wb_async_avr_if.master       wb
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_PEND = 2'd1,
    ST_WR_PEND = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [31:0]              adr_q, adr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [31:0]              rdata_q, rdata_d;
  logic [3:0]               be_q, be_d;
  logic                     ie_q, ie_d;
  logic                     done_flag_q, done_flag_d;
  logic                     err_flag_q, err_flag_d;
  logic                     rd_q, rd_d;
  logic                     wr_q, wr_d;
  logic                     irq_q, irq_d;
  logic [P_SYNC_STAGES-1:0] sync_q, sync_d;
  logic                     done_dly_q, done_dly_d;

  logic       hit;
  logic [3:0] off;
  logic       busy;
  logic       done_s;
  logic       done_rise;
  logic [7:0] status;

  assign hit       = (adr[5:4] == P_BASE_ADR[5:4]);
  assign off       = adr[3:0];
  assign busy      = (state_q != ST_IDLE);
  assign done_s    = sync_q[P_SYNC_STAGES-1];
  assign done_rise = done_s & ~done_dly_q;
  assign status    = {be_q, ie_q, err_flag_q, done_flag_q, busy};

  assign out_en = iore & hit;

  always_comb begin
    dbus_out = 8'h00;
    if (out_en) begin
      case (off[3:2])
        2'd0:    dbus_out = adr_q[{off[1:0], 3'b000} +: 8];
        2'd1:    dbus_out = rdata_q[{off[1:0], 3'b000} +: 8];
        2'd2:    dbus_out = (off == 4'd8) ? status : 8'h00;
        default: dbus_out = 8'h00;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    be_d        = be_q;
    ie_d        = ie_q;
    done_flag_d = done_flag_q;
    err_flag_d  = err_flag_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    sync_d      = {sync_q[P_SYNC_STAGES-2:0], wb.wb_done};
    done_dly_d  = done_s;

    // Register writes; transaction set-up is frozen while a request is in flight.
    if (iowe && hit) begin
      if (off[3:2] == 2'd0) begin
        if (!busy) adr_d[{off[1:0], 3'b000} +: 8] = dbus_in;
      end else if (off[3:2] == 2'd1) begin
        if (!busy) wdata_d[{off[1:0], 3'b000} +: 8] = dbus_in;
      end else if (off == 4'd8) begin
        ie_d = dbus_in[3];
        if (dbus_in[1]) done_flag_d = 1'b0;
        if (!busy) begin
          be_d = dbus_in[7:4];
          if (dbus_in[0]) begin
            state_d     = ST_RD_PEND;
            rd_d        = 1'b1;
            done_flag_d = 1'b0;
            err_flag_d  = 1'b0;
          end else if (dbus_in[2]) begin
            state_d     = ST_WR_PEND;
            wr_d        = 1'b1;
            done_flag_d = 1'b0;
            err_flag_d  = 1'b0;
          end
        end
      end
    end

    // Evaluated after the W1C so a same-cycle done edge wins.
    case (state_q)
      ST_RD_PEND: begin
        if (done_rise) begin
          rd_d        = 1'b0;
          done_flag_d = 1'b1;
          rdata_d     = wb.wb_rdata;
          err_flag_d  = wb.wb_error;
          state_d     = ST_RELEASE;
        end
      end
      ST_WR_PEND: begin
        if (done_rise) begin
          wr_d        = 1'b0;
          done_flag_d = 1'b1;
          err_flag_d  = 1'b0;
          state_d     = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Wait out the WB-side stretch so the next request edge is distinct.
        if (!done_s) state_d = ST_IDLE;
      end
      default: ;
    endcase

    irq_d = done_flag_d & ie_d;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      adr_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      be_q        <= '0;
      ie_q        <= 1'b0;
      done_flag_q <= 1'b0;
      err_flag_q  <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      irq_q       <= 1'b0;
      sync_q      <= '0;
      done_dly_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      be_q        <= be_d;
      ie_q        <= ie_d;
      done_flag_q <= done_flag_d;
      err_flag_q  <= err_flag_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      irq_q       <= irq_d;
      sync_q      <= sync_d;
      done_dly_q  <= done_dly_d;
    end
  end

  assign wb.wb_adr   = adr_q;
  assign wb.wb_wdata = wdata_q;
  assign wb.wb_be    = be_q;
  assign wb.wb_read  = rd_q;
  assign wb.wb_write = wr_q;
  assign irq         = irq_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_avr2wb_async_avr.sv
// Randomised bench for avr2wb_async_avr against a register-level behavioural model.
module tb_avr2wb_async_avr;
  localparam int         P    = 2;
  localparam logic [5:0] BASE = 6'h30;

  logic       clk = 1'b0;
  logic       nrst;
  logic [5:0] adr;
  logic       iore, iowe;
  logic [7:0] dbus_in, dbus_out;
  logic       out_en, irq;
  logic [1:0] dbg_state;

  avr2wb_async_avr_if wbi ();

  avr2wb_async_avr #(.P_BASE_ADR(BASE), .P_SYNC_STAGES(P)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .adr       (adr),
    .iore      (iore),
    .iowe      (iowe),
    .dbus_in   (dbus_in),
    .dbus_out  (dbus_out),
    .out_en    (out_en),
    .irq       (irq),
    .dbg_state (dbg_state),
    .wb        (wbi.master)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  initial begin
    #400000;
    $display("FAIL watchdog: timeout reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  logic [31:0] m_adr, m_wdata, m_rdata;
  logic [3:0]  m_be;
  logic        m_ie, m_done, m_err, m_busy, m_req, m_rd;

  function automatic logic [7:0] m_status();
    return {m_be, m_ie, m_err, m_done, m_busy};
  endfunction

  task automatic model_reset();
    m_adr = 0; m_wdata = 0; m_rdata = 0; m_be = 0;
    m_ie = 0; m_done = 0; m_err = 0; m_busy = 0; m_req = 0; m_rd = 0;
  endtask

  task automatic model_write(input logic [5:0] a, input logic [7:0] d);
    int o;
    o = int'(a[3:0]);
    if (a[5:4] != BASE[5:4]) return;
    if (o < 4) begin
      if (!m_busy) m_adr[8*o +: 8] = d;
    end else if (o < 8) begin
      if (!m_busy) m_wdata[8*(o-4) +: 8] = d;
    end else if (o == 8) begin
      m_ie = d[3];
      if (d[1]) m_done = 0;
      if (!m_busy) begin
        m_be = d[7:4];
        if (d[0] || d[2]) begin
          m_busy = 1; m_req = 1; m_rd = d[0]; m_done = 0; m_err = 0;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic io_write(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    adr = a; dbus_in = d; iowe = 1'b1;
    @(negedge clk);
    iowe = 1'b0;
    model_write(a, d);
  endtask

  task automatic io_read(input logic [5:0] a, output logic [7:0] d);
    @(negedge clk);
    adr = a; iore = 1'b1;
    #1;
    d = dbus_out;
    chk("out_en", out_en, a[5:4] == BASE[5:4]);
    iore = 1'b0;
    #1;
    chk("bus_idle", {out_en, dbus_out}, 0);
  endtask

  task automatic check_all(input string tag);
    logic [7:0]  b;
    logic [31:0] w;
    chk({tag, ".wb_adr"},   wbi.wb_adr,   m_adr);
    chk({tag, ".wb_wdata"}, wbi.wb_wdata, m_wdata);
    chk({tag, ".wb_be"},    wbi.wb_be,    m_be);
    chk({tag, ".wb_read"},  wbi.wb_read,  m_req & m_rd);
    chk({tag, ".wb_write"}, wbi.wb_write, m_req & ~m_rd);
    chk({tag, ".irq"},      irq,          m_done & m_ie);
    chk({tag, ".dbg_busy"}, dbg_state != 2'd0, m_busy);
    io_read(BASE + 6'd8, b);
    chk({tag, ".status"}, b, m_status());
    for (int i = 0; i < 4; i++) begin
      io_read(BASE + 6'(i), b);
      w[8*i +: 8] = b;
    end
    chk({tag, ".adr_rb"}, w, m_adr);
    for (int i = 0; i < 4; i++) begin
      io_read(BASE + 6'(4 + i), b);
      w[8*i +: 8] = b;
    end
    chk({tag, ".rdata_rb"}, w, m_rdata);
    io_read(BASE + 6'($urandom_range(9, 15)), b);
    chk({tag, ".unused_rd"}, b, 0);
  endtask

  // Completes the pending transaction from the WB side.
  task automatic run_done(input logic [31:0] rdata, input logic err, input int lat, input int hold);
    int         cnt;
    logic [7:0] b;
    repeat (lat) @(negedge clk);
    chk("req_held", wbi.wb_read | wbi.wb_write, 1);
    wbi.wb_rdata = rdata; wbi.wb_error = err; wbi.wb_done = 1'b1;
    cnt = 0;
    while ((wbi.wb_read | wbi.wb_write) && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("req_fall_lat", (cnt >= P + 1 && cnt <= P + 2), 1);
    m_req = 0; m_done = 1;
    if (m_rd) begin m_rdata = rdata; m_err = err; end
    else m_err = 0;
    wbi.wb_rdata = $urandom; wbi.wb_error = ~err;
    io_read(BASE + 6'd8, b);
    chk("status_release", b, m_status());
    repeat (hold) @(negedge clk);
    wbi.wb_done = 1'b0;
    repeat (P + 3) @(negedge clk);
    m_busy = 0;
  endtask

  task automatic setup(input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) io_write(BASE + 6'(i), a[8*i +: 8]);
    for (int i = 0; i < 4; i++) io_write(BASE + 6'(4 + i), d[8*i +: 8]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] ctrl;
    nrst = 1'b0; adr = '0; iore = 1'b0; iowe = 1'b0; dbus_in = '0;
    wbi.wb_rdata = '0; wbi.wb_done = 1'b0; wbi.wb_error = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    check_all("reset");

    // write transaction
    setup(32'h0000_1234, 32'hCAFE_BABE);
    io_write(BASE + 6'd8, 8'hF4);
    check_all("wr_start");
    run_done(32'h1357_9BDF, 1'b0, 2, 12);
    check_all("wr_done");

    // read transactions, clean and erroring
    io_write(BASE + 6'd8, 8'h01);
    run_done(32'hDEAD_BEEF, 1'b0, 3, 4);
    check_all("rd_ok");
    io_write(BASE + 6'd8, 8'h01);
    run_done(32'h0BAD_F00D, 1'b1, 1, 4);
    check_all("rd_err");

    // interrupt and W1C
    io_write(BASE + 6'd8, 8'h08);
    io_write(BASE + 6'd8, 8'h09);
    run_done(32'h1122_3344, 1'b0, 0, 2);
    check_all("irq_set");
    io_write(BASE + 6'd8, 8'h0A);
    check_all("irq_w1c");

    // read wins, busy-time writes ignored
    io_write(BASE + 6'd8, 8'h05);
    check_all("rd_wins");
    io_write(BASE + 6'd0, 8'hFF);
    io_write(BASE + 6'd8, 8'h04);
    check_all("busy_ignore");
    run_done(32'hA5A5_5A5A, 1'b0, 2, 3);
    check_all("busy_done");

    // out-of-window accesses
    io_write(6'h00, 8'h77);
    io_write(6'h08, 8'h05);
    check_all("miss");

    // reset in WR_PEND
    io_write(BASE + 6'd8, 8'hF4);
    @(negedge clk); nrst = 1'b0;
    @(negedge clk); nrst = 1'b1;
    model_reset();
    check_all("mid_reset");
    wbi.wb_done = 1'b1;
    repeat (8) @(negedge clk);
    wbi.wb_done = 1'b0;
    repeat (P + 3) @(negedge clk);
    check_all("post_reset_done");

    // randomised transactions
    for (int n = 0; n < 25; n++) begin
      setup($urandom, $urandom);
      if ($urandom_range(0, 1) == 1) io_write(BASE + 6'($urandom_range(9, 15)), 8'($urandom));
      ctrl = 8'($urandom) & 8'hFF;
      if (!ctrl[0] && !ctrl[2]) ctrl[2] = 1'b1;
      io_write(BASE + 6'd8, ctrl);
      check_all("rnd_start");
      for (int k = 0; k < int'($urandom_range(0, 3)); k++)
        io_write(BASE + 6'($urandom_range(0, 15)), 8'($urandom));
      chk("rnd_busy_adr", wbi.wb_adr, m_adr);
      run_done($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 6), $urandom_range(0, 8));
      check_all("rnd_done");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
